// File: rtl/fpu_pkg.sv
// Shared single-precision FPU types and constants.
package fpu_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } float_t;

  localparam int          FP_BIAS    = 127;
  localparam logic [31:0] FP_QNAN    = 32'h7fc00000;
  localparam int          FP_EXP_MAX = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DIV   = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } fdiv_state_t;

endpackage

// File: rtl/fdiv_mant_core.sv
// Radix-2 restoring mantissa divider: 25 quotient bits (24 mantissa + guard), MSB first.
// FDIV_EARLY_TERM_EN stops iterating as soon as the remainder is exactly zero.
module fdiv_mant_core
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic [24:0] dividend,
  input  logic [23:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [22:0] quot,
  output logic        guard,
  output logic        sticky
);

  logic [4:0]  cnt;
  logic [24:0] rem;
  logic [24:0] diff;
  logic [23:0] dvs;
  logic [23:0] q;
  logic        run;
  logic        fits;
  logic        last;

  assign fits = (rem >= {1'b0, dvs});
  assign diff = fits ? (rem - {1'b0, dvs}) : rem;

`ifdef FDIV_EARLY_TERM_EN
  assign last = (cnt == 5'd0) || (diff == 25'd0);
`else
  assign last = (cnt == 5'd0);
`endif

  assign busy   = run;
  assign done   = run & last;
  assign quot   = q[23:1];
  assign guard  = q[0];
  assign sticky = (rem != 25'd0);

  // The dividend is pre-normalised into [divisor, 2*divisor), so the leading
  // quotient bit (cnt == 24) is always 1 and is not stored.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      run <= 1'b0;
      cnt <= 5'd0;
      rem <= 25'd0;
      dvs <= 24'd0;
      q   <= 24'd0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= 5'd24;
      rem <= dividend;
      dvs <= divisor;
      q   <= 24'd0;
    end else if (run) begin
      rem <= {diff[23:0], 1'b0};
      if (cnt != 5'd24) q[cnt] <= fits;
      cnt <= cnt - 5'd1;
      if (last) run <= 1'b0;
    end
  end

endmodule

// File: rtl/fdiv_seq.sv
// Multi-cycle IEEE-754 single-precision divider y = x1 / x2 with valid/ready handshakes.
// Optional early termination on zero remainder: FDIV_EARLY_TERM_EN.
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   DIV   | mantissa core iterating
//   ROUND | round-to-nearest-even, range check
//   DONE  | result presented until out_ready
module fdiv_seq
  import fpu_pkg::*;
#(
  parameter int EXP_W  = 8,
  parameter int MANT_W = 23,
  parameter int BIAS   = FP_BIAS
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);

  localparam logic signed [9:0] E_MAX = 10'(FP_EXP_MAX);

  fdiv_state_t       state, state_nxt;
  float_t            x1f, x2f;
  logic [MANT_W:0]   m1, m2;
  logic              lt, special, s_in;
  logic [31:0]       spec_y, y_nxt;
  logic              spec_ovf, ovf_nxt, udf_nxt, s_r, s_nxt;
  logic signed [9:0] e_load, e_r, e_nxt, e_rnd;
  logic              start, mc_busy, mc_done, mc_guard, mc_sticky, rnd_up, carry;
  logic [22:0]       mc_quot, frac;

  assign x1f  = x1;
  assign x2f  = x2;
  assign s_in = x1f.sign ^ x2f.sign;
  assign m1   = {1'b1, x1f.mant};
  assign m2   = {1'b1, x2f.mant};
  assign lt   = (m1 < m2);

  assign special = (x1f.exp == '0) || (x1f.exp == '1) ||
                   (x2f.exp == '0) || (x2f.exp == '1);
  assign e_load  = 10'({2'b00, x1f.exp}) - 10'({2'b00, x2f.exp}) + 10'(BIAS) - {9'd0, lt};

  always_comb begin
    spec_y   = {s_in, 31'd0};
    spec_ovf = 1'b0;
    if (x1f.exp == '1 || x2f.exp == '1) begin
      spec_y = FP_QNAN;
    end else if (x2f.exp == '0) begin
      spec_y   = {s_in, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
      spec_ovf = 1'b1;
    end
  end

  assign start = (state == IDLE) && in_valid && !special;

  fdiv_mant_core u_core (
    .clk      (clk),
    .rstn     (rstn),
    .start    (start),
    .dividend (lt ? {m1, 1'b0} : {1'b0, m1}),
    .divisor  (m2),
    .busy     (mc_busy),
    .done     (mc_done),
    .quot     (mc_quot),
    .guard    (mc_guard),
    .sticky   (mc_sticky)
  );

  // Carry out of the 23 stored fraction bits means 1.111..1 rounded to 2.0.
  assign rnd_up         = mc_guard & (mc_sticky | mc_quot[0]);
  assign {carry, frac}  = {1'b0, mc_quot} + {23'd0, rnd_up};
  assign e_rnd          = e_r + {9'd0, carry};

  always_comb begin
    state_nxt = state;
    y_nxt     = y;
    ovf_nxt   = ovf;
    udf_nxt   = udf;
    e_nxt     = e_r;
    s_nxt     = s_r;
    case (state)
      IDLE: if (in_valid) begin
        s_nxt = s_in;
        e_nxt = e_load;
        if (special) begin
          y_nxt     = spec_y;
          ovf_nxt   = spec_ovf;
          udf_nxt   = 1'b0;
          state_nxt = DONE;
        end else begin
          state_nxt = DIV;
        end
      end
      DIV: if (mc_done) state_nxt = ROUND;
      ROUND: begin
        ovf_nxt = 1'b0;
        udf_nxt = 1'b0;
        if (e_rnd >= E_MAX) begin
          y_nxt   = {s_r, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          ovf_nxt = 1'b1;
        end else if (e_rnd <= 10'sd0) begin
          y_nxt   = {s_r, 31'd0};
          udf_nxt = 1'b1;
        end else begin
          y_nxt = {s_r, e_rnd[EXP_W-1:0], frac};
        end
        state_nxt = DONE;
      end
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      y     <= 32'd0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
      e_r   <= 10'sd0;
      s_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      y     <= y_nxt;
      ovf   <= ovf_nxt;
      udf   <= udf_nxt;
      e_r   <= e_nxt;
      s_r   <= s_nxt;
    end
  end

  assign in_ready  = (state == IDLE) && !mc_busy;
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fdiv_seq.sv
// Directed bench for fdiv_seq with hand-computed quotients and latencies.
module tb_fdiv_seq;

`ifdef FDIV_EARLY_TERM_EN
  localparam int LAT_EXACT = 3;
`else
  localparam int LAT_EXACT = 27;
`endif
  localparam int LAT_FULL = 27;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = 32'd0;
  logic [31:0] x2 = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] y;
  logic        ovf, udf;

  int checks = 0;
  int errors = 0;
  int lat;
  logic [31:0] y_hold;

  fdiv_seq dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept edge counts as 1; returns edges until out_valid is seen (60 = timed out).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    x1 = a; x2 = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    while (n < 60) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      n++;
    end
  endtask

  task automatic consume();
    @(posedge clk);
    @(negedge clk);
    chk("ready_after", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_flags", {30'd0, ovf, udf}, 32'd0);
    rstn = 1'b1;

    run_op(32'h3f800000, 32'h40000000, lat);
    chk("half_lat", lat, LAT_EXACT);
    chk("half_y", y, 32'h3f000000);
    chk("half_flags", {30'd0, ovf, udf}, 32'd0);
    consume();

    run_op(32'h3f800000, 32'h40400000, lat);
    chk("third_lat", lat, LAT_FULL);
    chk("third_y", y, 32'h3eaaaaab);
    consume();

    run_op(32'h3f800000, 32'hc0400000, lat);
    chk("negthird_y", y, 32'hbeaaaaab);
    consume();

    run_op(32'h3f800000, 32'h00000000, lat);
    chk("divzero_lat", lat, 1);
    chk("divzero_y", y, 32'h7f800000);
    chk("divzero_ovf", {31'd0, ovf}, 32'd1);
    consume();

    run_op(32'h7fc00000, 32'h40000000, lat);
    chk("nan_lat", lat, 1);
    chk("nan_y", y, 32'h7fc00000);
    chk("nan_flags", {30'd0, ovf, udf}, 32'd0);
    consume();

    run_op(32'h7f000000, 32'h00800000, lat);
    chk("ovf_lat", lat, LAT_EXACT);
    chk("ovf_y", y, 32'h7f800000);
    chk("ovf_flags", {30'd0, ovf, udf}, 32'd2);
    consume();

    run_op(32'h00800000, 32'h40000000, lat);
    chk("udf_lat", lat, LAT_EXACT);
    chk("udf_y", y, 32'h00000000);
    chk("udf_flags", {30'd0, ovf, udf}, 32'd1);
    consume();

    out_ready = 1'b0;
    run_op(32'h3f800000, 32'h40400000, lat);
    chk("hold_lat", lat, LAT_FULL);
    y_hold = y;
    for (int i = 0; i < 5; i++) begin
      x1 = 32'h40800000; x2 = 32'h40000000; in_valid = (i % 2) == 0;
      @(posedge clk);
      @(negedge clk);
      chk("hold_y", y, 32'h3eaaaaab);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("hold_y_start", y_hold, 32'h3eaaaaab);
    consume();
    chk("hold_released", {31'd0, out_valid}, 32'd0);

    @(negedge clk);
    x1 = 32'h3f800000; x2 = 32'h40400000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_y", y, 32'd0);

    run_op(32'h40800000, 32'h40000000, lat);
    chk("post_lat", lat, LAT_EXACT);
    chk("post_y", y, 32'h40000000);
    consume();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
